// File: rtl/bsn_ctrl_pkg.sv
// Shared types and helpers for the bitstream-network control blocks.
package bsn_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} seq_state_t;

    // Counter width able to hold 0..len inclusive.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/layer_weight_bank.sv
// Per-element writable weight register bank with address range check.
module layer_weight_bank
    import bsn_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE   = 2,
    parameter int NEURON_COUNT = 2,
    parameter int WEIGHT_LEN   = 16,
    localparam int NW = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
    localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_allow,
    input  logic [NW-1:0]         wr_neuron,
    input  logic [IW-1:0]         wr_input,
    input  logic [WEIGHT_LEN-1:0] wr_data,
    output logic                  wr_ok,
    output logic [NEURON_COUNT-1:0][INPUT_SIZE-1:0][WEIGHT_LEN-1:0] weights
);

    // Address fields may be wider than the array when counts are not powers of two.
    assign wr_ok = (int'(wr_neuron) < NEURON_COUNT) && (int'(wr_input) < INPUT_SIZE);

    always_ff @(posedge clk) begin
        if (rst)
            weights <= '0;
        else if (wr_en && wr_allow && wr_ok)
            weights[wr_neuron][wr_input] <= wr_data;
    end

endmodule

// File: rtl/layer_sequencer.sv
// Run controller for one bitstream layer: weight bank, flush/run/done FSM, per-neuron ones counters.
module layer_sequencer
    import bsn_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE   = 2,
    parameter int NEURON_COUNT = 2,
    parameter int WEIGHT_LEN   = 16,
    parameter int STREAM_LEN   = 256,
    parameter int WARMUP       = 2,
    parameter int FLUSH_LEN    = 2,
    localparam int CNT_W = cnt_width(STREAM_LEN),
    localparam int NW = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
    localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [NW-1:0]           wr_neuron,
    input  logic [IW-1:0]           wr_input,
    input  logic [WEIGHT_LEN-1:0]   wr_data,
    output logic                    wr_err,
    output logic                    layer_n_rst,
    output logic [NEURON_COUNT-1:0][INPUT_SIZE-1:0][WEIGHT_LEN-1:0] layer_weights,
    input  logic [NEURON_COUNT-1:0] layer_output,
    output logic [NEURON_COUNT-1:0][CNT_W-1:0] result_count,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int RUN_LEN = WARMUP + STREAM_LEN;
    localparam int PH_MAX  = (RUN_LEN > FLUSH_LEN) ? RUN_LEN : FLUSH_LEN;
    localparam int PH_W    = $clog2(PH_MAX + 1);

    seq_state_t      state, state_n;
    logic [PH_W-1:0] phase;
    logic            wr_allow, wr_ok, counting, clr;
    logic [CNT_W-1:0] cnt [NEURON_COUNT];

    assign wr_allow = (state == IDLE) || (state == DONE);
    assign clr      = (state == IDLE) && start;
    assign counting = (state == RUN) && (int'(phase) >= WARMUP);

    layer_weight_bank #(
        .INPUT_SIZE  (INPUT_SIZE),
        .NEURON_COUNT(NEURON_COUNT),
        .WEIGHT_LEN  (WEIGHT_LEN)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_allow (wr_allow),
        .wr_neuron(wr_neuron),
        .wr_input (wr_input),
        .wr_data  (wr_data),
        .wr_ok    (wr_ok),
        .weights  (layer_weights)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = FLUSH;
            FLUSH:   if (phase == PH_W'(FLUSH_LEN - 1)) state_n = RUN;
            RUN:     if (phase == PH_W'(RUN_LEN - 1)) state_n = DONE;
            DONE:    if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            busy         <= 1'b0;
            layer_n_rst  <= 1'b0;
            result_valid <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= (state_n != state || state == IDLE || state == DONE) ? '0 : phase + 1'b1;
            busy         <= (state_n != IDLE);
            layer_n_rst  <= (state_n == RUN);
            result_valid <= (state_n == DONE);
            wr_err       <= wr_en && !(wr_allow && wr_ok);
        end
    end

    for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || clr)
                cnt[g] <= '0;
            else if (counting && layer_output[g])
                cnt[g] <= cnt[g] + 1'b1;
        end
        assign result_count[g] = cnt[g];
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: weight writes, windows, handshake, reset abort.
module tb_layer_sequencer;

    localparam int SL = 8, WU = 2, FL = 2, RL = WU + SL, CW = 4;

    typedef logic [1:0][CW-1:0] cnt_t;
    typedef logic [1:0][1:0][15:0] wbank_t;
    typedef struct { logic n; logic i; logic [15:0] d; logic exp_err; } wvec_t;
    typedef struct { int mode; int hold; bit bad_wr; cnt_t exp; } win_t;

    logic clk = 1'b0;
    logic rst, start, wr_en, wr_neuron, wr_input, result_ready;
    logic [15:0] wr_data;
    logic busy, wr_err, layer_n_rst, result_valid;
    wbank_t layer_weights;
    logic [1:0] layer_output;
    cnt_t result_count;

    logic [1:0] w3_neuron, w3_input;
    logic w3_en;
    logic [15:0] w3_data;
    logic w3_busy, w3_err, w3_nrst, w3_valid;
    logic [2:0][2:0][15:0] w3_weights;
    logic [2:0][CW-1:0] w3_count;

    int errors = 0, checks = 0;
    cnt_t sb[$];
    wbank_t wm;
    logic [2:0][2:0][15:0] w3m;
    logic [1:0] pat [RL];
    wvec_t wt [4];
    win_t wins [4];

    always #5 clk = ~clk;

    layer_sequencer #(.INPUT_SIZE(2), .NEURON_COUNT(2), .WEIGHT_LEN(16),
                      .STREAM_LEN(SL), .WARMUP(WU), .FLUSH_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_input(wr_input), .wr_data(wr_data),
        .wr_err(wr_err), .layer_n_rst(layer_n_rst), .layer_weights(layer_weights),
        .layer_output(layer_output), .result_count(result_count),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    // Three-neuron/three-input instance so the range check has unreachable addresses.
    layer_sequencer #(.INPUT_SIZE(3), .NEURON_COUNT(3), .WEIGHT_LEN(16),
                      .STREAM_LEN(SL), .WARMUP(WU), .FLUSH_LEN(FL)) dut3 (
        .clk(clk), .rst(rst), .start(1'b0), .busy(w3_busy),
        .wr_en(w3_en), .wr_neuron(w3_neuron), .wr_input(w3_input), .wr_data(w3_data),
        .wr_err(w3_err), .layer_n_rst(w3_nrst), .layer_weights(w3_weights),
        .layer_output(3'b000), .result_count(w3_count),
        .result_valid(w3_valid), .result_ready(1'b0)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic w3_write(input logic [1:0] n, input logic [1:0] i, input logic [15:0] d,
                            input logic exp_err);
        w3_en = 1'b1; w3_neuron = n; w3_input = i; w3_data = d;
        tick;
        w3_en = 1'b0;
        if (!exp_err) w3m[n][i] = d;
        check("range_wr_err", w3_err, exp_err);
        check("range_weights", w3_weights, w3m);
    endtask

    task automatic run_window(input int mode, input int hold, input bit bad_wr, input cnt_t exp_in);
        cnt_t exp, got;
        logic [15:0] wd;
        int nrst_bad, stable_bad, waited;
        for (int p = 0; p < RL; p++)
            pat[p] = (mode == 0) ? 2'b01 : (mode == 1) ? ((p % 2 == 0) ? 2'b11 : 2'b00) : 2'($urandom);
        exp = exp_in;
        if (mode == 2) begin
            exp = '0;
            for (int p = WU; p < RL; p++)
                for (int n = 0; n < 2; n++) exp[n] = exp[n] + CW'(pat[p][n]);
        end
        sb.push_back(exp);
        wd = 16'($urandom);
        start = 1'b1; wr_en = 1'b1; wr_neuron = 1'b1; wr_input = 1'b1; wr_data = wd;
        layer_output = 2'b11;
        tick;
        start = 1'b0; wr_en = 1'b0;
        wm[1][1] = wd;
        check("start_write_lands", layer_weights, wm);
        check("flush_cnt_clear", result_count, 0);
        check("flush_busy", busy, 1);
        nrst_bad = 0;
        for (int c = 1; c <= FL + RL; c++) begin
            if (layer_n_rst !== (c > FL)) nrst_bad++;
            layer_output = (c > FL) ? pat[c - FL - 1] : 2'b11;
            if (bad_wr && c == FL + 6) begin
                wr_en = 1'b1; wr_neuron = 1'b0; wr_input = 1'b0; wr_data = ~wm[0][0];
            end
            tick;
            if (bad_wr && c == FL + 6) begin
                wr_en = 1'b0;
                check("run_wr_err", wr_err, 1);
                check("run_wr_no_effect", layer_weights, wm);
            end
        end
        check("n_rst_sequence_bad_cycles", nrst_bad, 0);
        layer_output = 2'b11;
        check("valid_latency", result_valid, 1);
        check("done_n_rst", layer_n_rst, 0);
        stable_bad = 0;
        for (int h = 0; h < hold; h++) begin
            result_ready = 1'b0;
            start = 1'b1;
            if (h == 1) begin
                wd = 16'($urandom);
                wr_en = 1'b1; wr_neuron = 1'b0; wr_input = 1'b1; wr_data = wd;
            end
            tick;
            if (h == 1) begin
                wr_en = 1'b0;
                wm[0][1] = wd;
                check("done_wr_err", wr_err, 0);
                check("done_write_lands", layer_weights, wm);
            end
            if (result_valid !== 1'b1 || result_count !== exp) stable_bad++;
        end
        if (hold > 0) check("hold_stable_bad_cycles", stable_bad, 0);
        result_ready = 1'b1;
        waited = 0;
        while (!result_valid && waited < 20) begin
            tick;
            waited++;
        end
        if (result_valid) begin
            got = result_count;
            check("result_counts", got, sb.pop_front());
        end else begin
            errors++;
            $display("FAIL result_timeout: result_valid never rose");
            void'(sb.pop_front());
        end
        tick;
        start = 1'b0; result_ready = 1'b0;
        check("after_accept_valid", result_valid, 0);
        check("after_accept_busy", busy, 0);
        tick;
        check("no_chain_busy", busy, 0);
        check("window_weights_kept", layer_weights, wm);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_neuron = 1'b0; wr_input = 1'b0;
        wr_data = '0; result_ready = 1'b0; layer_output = 2'b00;
        w3_en = 1'b0; w3_neuron = '0; w3_input = '0; w3_data = '0;
        wm = '0; w3m = '0;

        wt[0] = '{1'b0, 1'b0, 16'h1234, 1'b0};
        wt[1] = '{1'b0, 1'b1, 16'hABCD, 1'b0};
        wt[2] = '{1'b1, 1'b0, 16'h00FF, 1'b0};
        wt[3] = '{1'b1, 1'b1, 16'h8001, 1'b0};
        wins[0] = '{0, 0, 1'b0, {4'd0, 4'd8}};
        wins[1] = '{1, 0, 1'b0, {4'd4, 4'd4}};
        wins[2] = '{0, 5, 1'b1, {4'd0, 4'd8}};
        wins[3] = '{2, 2, 1'b0, '0};

        tick; tick;
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_n_rst", layer_n_rst, 0);
        check("reset_valid", result_valid, 0);
        check("reset_wr_err", wr_err, 0);
        check("reset_counts", result_count, 0);
        check("reset_weights", layer_weights, 0);

        foreach (wt[k]) begin
            wr_en = 1'b1; wr_neuron = wt[k].n; wr_input = wt[k].i; wr_data = wt[k].d;
            tick;
            wr_en = 1'b0;
            if (!wt[k].exp_err) wm[wt[k].n][wt[k].i] = wt[k].d;
            check("idle_wr_err", wr_err, wt[k].exp_err);
            check("idle_weights", layer_weights, wm);
        end

        w3_write(2'd2, 2'd2, 16'h5A5A, 1'b0);
        w3_write(2'd3, 2'd0, 16'hDEAD, 1'b1);
        tick;
        check("wr_err_pulse_clears", w3_err, 0);
        w3_write(2'd0, 2'd3, 16'hBEEF, 1'b1);

        foreach (wins[k]) run_window(wins[k].mode, wins[k].hold, wins[k].bad_wr, wins[k].exp);

        // Abort a window with reset at RUN phase 5.
        start = 1'b1; layer_output = 2'b11;
        tick;
        start = 1'b0;
        for (int c = 1; c < FL + 6; c++) tick;
        check("pre_rst_counts", result_count, {4'd3, 4'd3});
        rst = 1'b1;
        tick;
        rst = 1'b0;
        wm = '0;
        check("abort_busy", busy, 0);
        check("abort_n_rst", layer_n_rst, 0);
        check("abort_valid", result_valid, 0);
        check("abort_counts", result_count, 0);
        check("abort_weights", layer_weights, 0);
        tick;
        run_window(1, 0, 1'b0, {4'd4, 4'd4});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
